receive_cgrundey: RTL and testbench

RECEIVE_CGRUNDEY -- requirements
Module: receive_cgrundey

---
 rtl/receive_cgrundey.sv | 115 +++++++++++
 tb/tb_receive_cgrundey.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/receive_cgrundey.sv
// Receive-side checker for the counter/converter link: validates each strobed
// word's converter field, tracks the binary count sequence and tallies bad words.
module receive_cgrundey (
  input  logic        clk,
  input  logic        clear,
  input  logic        rx_en,
  input  logic [11:0] rx_word,
  output logic [5:0]  data_out,
  output logic        locked,
  output logic        bcd_err,
  output logic        seq_err,
  output logic [7:0]  err_cnt
);

  typedef enum logic {HUNT, LOCK} state_t;

  state_t      state;
  logic [1:0]  good_run;
  logic        bad_run;
  logic [5:0]  prev;
  logic        first_word;

  logic [5:0]  count;
  logic [5:0]  tens;
  logic [5:0]  units;
  logic [5:0]  expected_field;
  logic        bcd_ok;
  logic        is_advance;
  logic        is_hold;
  logic        seq_ok;
  logic        word_bad;

  // The converter field carries tens and units with the units LSB implied by count[0].
  always_comb begin
    count          = rx_word[11:6];
    tens           = count / 6'd10;
    units          = count % 6'd10;
    expected_field = {tens[2:0], units[3:1]};
    bcd_ok         = (rx_word[5:0] == expected_field);
    is_advance     = (count == prev + 6'd1);
    is_hold        = (count == prev);
    seq_ok         = is_advance || is_hold;
    word_bad       = !bcd_ok || ((state == LOCK) && !seq_ok);
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state      <= HUNT;
      good_run   <= 2'd0;
      bad_run    <= 1'b0;
      prev       <= 6'd0;
      first_word <= 1'b1;
      data_out   <= 6'd0;
      locked     <= 1'b0;
      bcd_err    <= 1'b0;
      seq_err    <= 1'b0;
      err_cnt    <= 8'd0;
    end else begin
      bcd_err <= 1'b0;
      seq_err <= 1'b0;
      if (rx_en) begin
        if (bcd_ok)
          data_out <= count;
        if (word_bad && (err_cnt != 8'hFF))
          err_cnt <= err_cnt + 8'd1;

        case (state)
          HUNT: begin
            if (!bcd_ok) begin
              bcd_err  <= 1'b1;
              good_run <= 2'd0;
            end else begin
              prev       <= count;
              first_word <= 1'b0;
              if (first_word) begin
                good_run <= 2'd1;
              end else if (is_advance) begin
                good_run <= good_run + 2'd1;
                if (good_run == 2'd2) begin
                  state  <= LOCK;
                  locked <= 1'b1;
                end
              end else if (!is_hold) begin
                good_run <= 2'd1;
              end
            end
          end

          LOCK: begin
            if (bcd_ok && seq_ok) begin
              prev    <= count;
              bad_run <= 1'b0;
            end else begin
              // A single bad word resyncs to it; a second in a row drops lock.
              bcd_err <= !bcd_ok;
              seq_err <= !seq_ok;
              prev    <= count;
              if (bad_run) begin
                state    <= HUNT;
                locked   <= 1'b0;
                good_run <= 2'd0;
                bad_run  <= 1'b0;
              end else begin
                bad_run <= 1'b1;
              end
            end
          end

          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_receive_cgrundey.sv
// Self-checking bench for receive_cgrundey: table-driven vectors feed a
// scoreboard queue that is compared one clock after each strobe.
module tb_receive_cgrundey;

  logic        clk = 1'b0;
  logic        clear;
  logic        rx_en;
  logic [11:0] rx_word;
  logic [5:0]  data_out;
  logic        locked;
  logic        bcd_err;
  logic        seq_err;
  logic [7:0]  err_cnt;

  int compared   = 0;
  int mismatched = 0;

  logic [16:0] exp_q[$];
  string       tag_q[$];

  typedef struct {
    logic        en;
    logic [11:0] word;
    logic [16:0] want;
    string       tag;
  } vec_t;

  vec_t tbl[16];

  receive_cgrundey dut (
    .clk      (clk),
    .clear    (clear),
    .rx_en    (rx_en),
    .rx_word  (rx_word),
    .data_out (data_out),
    .locked   (locked),
    .bcd_err  (bcd_err),
    .seq_err  (seq_err),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] pk(input logic [5:0] d, input logic l, input logic be,
                                     input logic se, input logic [7:0] e);
    return {d, l, be, se, e};
  endfunction

  function automatic vec_t mk(input logic en, input logic [11:0] word,
                              input logic [16:0] want, input string tag);
    vec_t v;
    v.en   = en;
    v.word = word;
    v.want = want;
    v.tag  = tag;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [16:0] got, input logic [16:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got data_out=%0d locked=%0b bcd_err=%0b seq_err=%0b err_cnt=%0d, expected data_out=%0d locked=%0b bcd_err=%0b seq_err=%0b err_cnt=%0d",
               tag, got[16:11], got[10], got[9], got[8], got[7:0],
               want[16:11], want[10], want[9], want[8], want[7:0]);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [11:0] word,
                               input logic [16:0] want, input string tag);
    @(negedge clk);
    rx_en   = en;
    rx_word = word;
    exp_q.push_back(want);
    tag_q.push_back(tag);
  endtask

  task automatic pulseClear();
    @(negedge clk);
    rx_en = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Every driven cycle has exactly one expected record, compared just after the edge.
  always @(posedge clk) begin : scoreboard
    logic [16:0] want;
    string       tag;
    #1;
    if (exp_q.size() != 0) begin
      want = exp_q.pop_front();
      tag  = tag_q.pop_front();
      checkOutput(tag, {data_out, locked, bcd_err, seq_err, err_cnt}, want);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tbl[0]  = mk(1'b1, 12'h000, pk(6'd0,  1'b0, 1'b0, 1'b0, 8'd0), "lockup_w0");
    tbl[1]  = mk(1'b1, 12'h040, pk(6'd1,  1'b0, 1'b0, 1'b0, 8'd0), "lockup_w1");
    tbl[2]  = mk(1'b1, 12'h081, pk(6'd2,  1'b1, 1'b0, 1'b0, 8'd0), "lockup_w2");
    tbl[3]  = mk(1'b0, 12'hFFF, pk(6'd2,  1'b1, 1'b0, 1'b0, 8'd0), "idle_hold");
    tbl[4]  = mk(1'b1, 12'h0C1, pk(6'd3,  1'b1, 1'b0, 1'b0, 8'd0), "adv_3");
    tbl[5]  = mk(1'b1, 12'h102, pk(6'd4,  1'b1, 1'b0, 1'b0, 8'd0), "adv_4");
    tbl[6]  = mk(1'b1, 12'h142, pk(6'd5,  1'b1, 1'b0, 1'b0, 8'd0), "adv_5");
    tbl[7]  = mk(1'b1, 12'h180, pk(6'd5,  1'b1, 1'b1, 1'b0, 8'd1), "conv_fault");
    tbl[8]  = mk(1'b1, 12'h1C3, pk(6'd7,  1'b1, 1'b0, 1'b0, 8'd1), "after_fault");
    tbl[9]  = mk(1'b1, 12'h1C3, pk(6'd7,  1'b1, 1'b0, 1'b0, 8'd1), "hold_locked");
    tbl[10] = mk(1'b1, 12'hF30, pk(6'd60, 1'b1, 1'b0, 1'b1, 8'd2), "seq_jump");
    tbl[11] = mk(1'b1, 12'hF70, pk(6'd61, 1'b1, 1'b0, 1'b0, 8'd2), "resync_61");
    tbl[12] = mk(1'b1, 12'hFB1, pk(6'd62, 1'b1, 1'b0, 1'b0, 8'd2), "wrap_62");
    tbl[13] = mk(1'b1, 12'hFF1, pk(6'd63, 1'b1, 1'b0, 1'b0, 8'd2), "wrap_63");
    tbl[14] = mk(1'b1, 12'h000, pk(6'd0,  1'b1, 1'b0, 1'b0, 8'd2), "wrap_0");
    tbl[15] = mk(1'b0, 12'h000, pk(6'd0,  1'b1, 1'b0, 1'b0, 8'd2), "idle_end");

    clear   = 1'b1;
    rx_en   = 1'b0;
    rx_word = 12'h000;
    #1;
    checkOutput("reset_state", {data_out, locked, bcd_err, seq_err, err_cnt}, 17'd0);
    @(negedge clk);
    clear = 1'b0;

    for (int i = 0; i < 16; i++)
      applyStimulus(tbl[i].en, tbl[i].word, tbl[i].want, tbl[i].tag);

    // Loss of lock after two consecutive sequence breaks, then re-acquire in HUNT.
    pulseClear();
    applyStimulus(1'b1, 12'h204, pk(6'd8,  1'b0, 1'b0, 1'b0, 8'd0), "lol_w8");
    applyStimulus(1'b1, 12'h244, pk(6'd9,  1'b0, 1'b0, 1'b0, 8'd0), "lol_w9");
    applyStimulus(1'b1, 12'h288, pk(6'd10, 1'b1, 1'b0, 1'b0, 8'd0), "lol_w10");
    applyStimulus(1'b1, 12'h510, pk(6'd20, 1'b1, 1'b0, 1'b1, 8'd1), "lol_break1");
    applyStimulus(1'b1, 12'hA20, pk(6'd40, 1'b0, 1'b0, 1'b1, 8'd2), "lol_break2");
    applyStimulus(1'b1, 12'hA63, pk(6'd40, 1'b0, 1'b1, 1'b0, 8'd3), "hunt_bad_field");
    applyStimulus(1'b1, 12'hA60, pk(6'd41, 1'b0, 1'b0, 1'b0, 8'd3), "hunt_41");
    applyStimulus(1'b1, 12'hA60, pk(6'd41, 1'b0, 1'b0, 1'b0, 8'd3), "hunt_hold");
    applyStimulus(1'b1, 12'hAA1, pk(6'd42, 1'b0, 1'b0, 1'b0, 8'd3), "hunt_42");
    applyStimulus(1'b1, 12'hAE1, pk(6'd43, 1'b1, 1'b0, 1'b0, 8'd3), "relock_43");

    // Field 6'h3F can never match (tens never exceeds 6), so every word is bad.
    pulseClear();
    for (int i = 0; i < 300; i++) begin
      logic [5:0] bv;
      logic [7:0] ev;
      bv = 6'(i);
      ev = (i >= 254) ? 8'd255 : 8'(i + 1);
      applyStimulus(1'b1, {bv, 6'h3F}, pk(6'd0, 1'b0, 1'b1, 1'b0, ev), "saturate");
    end

    @(negedge clk);
    rx_en = 1'b0;
    #2;
    clear = 1'b1;
    #1;
    checkOutput("async_clear", {data_out, locked, bcd_err, seq_err, err_cnt}, 17'd0);
    @(negedge clk);
    clear = 1'b0;
    repeat (2) @(negedge clk);

    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
